// File: rtl/preg_free_list.sv
// Physical-register free list for the 2-wide rename stage: circular buffer of free pregs plus a
// free-bit scoreboard that screens retire-time releases for double-free, p0 and overflow.
module preg_free_list #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned WIDTH     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alloc_req    [0:WIDTH-1],
    output logic              o_alloc_grant,
    output logic [PREG_W-1:0] o_alloc_preg   [0:WIDTH-1],
    output logic              o_stall,
    input  logic              i_release_en   [0:WIDTH-1],
    input  logic [PREG_W-1:0] i_release_preg [0:WIDTH-1],
    output logic [PREG_W:0]   o_free_count,
    output logic              o_error
);

    localparam logic [PREG_W:0]   FULL_COUNT  = (PREG_W+1)'(NUM_PREGS);
    localparam logic [PREG_W:0]   RESET_COUNT = (PREG_W+1)'(NUM_PREGS - NUM_AREGS);
    localparam logic [PREG_W-1:0] RESET_TAIL  = PREG_W'(NUM_PREGS - NUM_AREGS);

    logic [PREG_W-1:0]    r_list [0:NUM_PREGS-1];
    logic [NUM_PREGS-1:0] r_free;
    logic [PREG_W-1:0]    r_head;
    logic [PREG_W-1:0]    r_tail;
    logic [PREG_W:0]      r_count;
    logic                 r_error;

    logic [PREG_W:0]      w_n;
    logic                 w_grant;
    logic [PREG_W:0]      w_push;
    logic [WIDTH-1:0]     w_rel_legal;
    logic [PREG_W-1:0]    w_push_idx [0:WIDTH-1];
    logic                 w_illegal;
    logic [NUM_PREGS-1:0] w_free_d;
    logic [PREG_W:0]      w_count_d;

    // Requesting lanes take consecutive entries from head in lane order.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_alloc_preg[i] = r_list[r_head + w_n[PREG_W-1:0]];
            if (i_alloc_req[i]) begin
                w_n = w_n + (PREG_W+1)'(1);
            end
        end
    end

    assign w_grant       = (w_n <= r_count);
    assign o_alloc_grant = w_grant;
    assign o_stall       = ~w_grant;

    always_comb begin
        w_free_d    = r_free;
        w_push      = '0;
        w_illegal   = 1'b0;
        w_rel_legal = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_push_idx[i] = r_tail + w_push[PREG_W-1:0];
            if (i_release_en[i]) begin
                // Setting the bit as each lane is accepted also rejects a same-cycle duplicate.
                if ((i_release_preg[i] != '0) && !w_free_d[i_release_preg[i]] &&
                    ((r_count + w_push) < FULL_COUNT)) begin
                    w_rel_legal[i]             = 1'b1;
                    w_free_d[i_release_preg[i]] = 1'b1;
                    w_push                     = w_push + (PREG_W+1)'(1);
                end else begin
                    w_illegal = 1'b1;
                end
            end
        end
        if (w_grant) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_alloc_req[i]) begin
                    w_free_d[o_alloc_preg[i]] = 1'b0;
                end
            end
        end
        w_count_d = r_count - (w_grant ? w_n : '0) + w_push;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NUM_PREGS); i++) begin
                r_list[i] <= (i < int'(NUM_PREGS - NUM_AREGS)) ? PREG_W'(i + int'(NUM_AREGS)) : '0;
                r_free[i] <= (i >= int'(NUM_AREGS));
            end
            r_head  <= '0;
            r_tail  <= RESET_TAIL;
            r_count <= RESET_COUNT;
            r_error <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_rel_legal[i]) begin
                    r_list[w_push_idx[i]] <= i_release_preg[i];
                end
            end
            if (w_grant) begin
                r_head <= r_head + w_n[PREG_W-1:0];
            end
            r_tail  <= r_tail + w_push[PREG_W-1:0];
            r_free  <= w_free_d;
            r_count <= w_count_d;
            r_error <= r_error | w_illegal;
        end
    end

    assign o_free_count = r_count;
    assign o_error      = r_error;

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: hand-derived vector table, then a queue-based reference model
// driving directed wrap-around and random allocate/release traffic.
module tb_preg_free_list;

    localparam int NP = 64;
    localparam int NA = 32;
    localparam int PW = 6;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req   [0:W-1];
    logic          grant;
    logic [PW-1:0] apreg [0:W-1];
    logic          stall;
    logic          ren   [0:W-1];
    logic [PW-1:0] rpreg [0:W-1];
    logic [PW:0]   cnt;
    logic          err;

    always #5 clk = ~clk;

    preg_free_list #(
        .NUM_PREGS(NP),
        .NUM_AREGS(NA),
        .PREG_W   (PW),
        .WIDTH    (W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alloc_req   (req),
        .o_alloc_grant (grant),
        .o_alloc_preg  (apreg),
        .o_stall       (stall),
        .i_release_en  (ren),
        .i_release_preg(rpreg),
        .o_free_count  (cnt),
        .o_error       (err)
    );

    typedef struct {
        bit          rst;
        bit [1:0]    req;
        bit [1:0]    ren;
        bit [PW-1:0] rp0;
        bit [PW-1:0] rp1;
        bit          chk_comb;
        bit          grant;
        bit [PW-1:0] ep0;
        bit [PW-1:0] ep1;
        bit [PW:0]   cnt;
        bit          err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    int   m_list[$];
    bit   m_free[NP];
    bit   m_err;
    int   held[$];

    function automatic vec_t mk(bit rs, bit [1:0] rq, bit [1:0] re, int p0, int p1, bit cc,
                                bit g, int e0, int e1, int c, bit er);
        vec_t v;
        v.rst = rs;  v.req = rq;  v.ren = re;
        v.rp0 = PW'(p0);  v.rp1 = PW'(p1);
        v.chk_comb = cc;  v.grant = g;
        v.ep0 = PW'(e0);  v.ep1 = PW'(e1);
        v.cnt = (PW+1)'(c);  v.err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, vec_no, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        @(negedge clk);
        rst      = v.rst;
        req[0]   = v.req[0];  req[1]   = v.req[1];
        ren[0]   = v.ren[0];  ren[1]   = v.ren[1];
        rpreg[0] = v.rp0;     rpreg[1] = v.rp1;
        #1;
        e = exp_q.pop_front();
        if (e.chk_comb) begin
            chk("grant", int'(grant), int'(e.grant));
            chk("stall", int'(stall), int'(!e.grant));
            if (e.grant && e.req[0]) chk("preg lane0", int'(apreg[0]), int'(e.ep0));
            if (e.grant && e.req[1]) chk("preg lane1", int'(apreg[1]), int'(e.ep1));
        end
        @(posedge clk);
        #1;
        chk("free_count", int'(cnt), int'(e.cnt));
        chk("error", int'(err), int'(e.err));
        vec_no++;
    endtask

    task automatic predict(inout vec_t v);
        int n;
        int k;
        int p;
        int tmp;
        bit seen[NP];
        int pushes[$];
        if (v.rst) begin
            m_list.delete();
            for (int i = NA; i < NP; i++) m_list.push_back(i);
            for (int i = 0; i < NP; i++) m_free[i] = (i >= NA);
            m_err = 1'b0;
            held.delete();
            v.chk_comb = 1'b0;
            v.cnt = (PW+1)'(m_list.size());
            v.err = 1'b0;
            return;
        end
        n = int'(v.req[0]) + int'(v.req[1]);
        v.chk_comb = 1'b1;
        v.grant = (n <= m_list.size());
        k = 0;
        if (v.grant && v.req[0]) begin
            v.ep0 = PW'(m_list[0]);
            k = 1;
        end
        if (v.grant && v.req[1]) v.ep1 = PW'(m_list[k]);
        seen = m_free;
        for (int l = 0; l < W; l++) begin
            if (v.ren[l]) begin
                p = (l == 0) ? int'(v.rp0) : int'(v.rp1);
                if (p != 0 && !seen[p] && (m_list.size() + pushes.size()) < NP) begin
                    seen[p] = 1'b1;
                    pushes.push_back(p);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (v.grant) begin
            repeat (n) begin
                tmp = m_list.pop_front();
                m_free[tmp] = 1'b0;
            end
        end
        foreach (pushes[i]) begin
            m_list.push_back(pushes[i]);
            m_free[pushes[i]] = 1'b1;
        end
        v.cnt = (PW+1)'(m_list.size());
        v.err = m_err;
    endtask

    task automatic run_model(input vec_t v);
        vec_t pv;
        pv = v;
        predict(pv);
        if (!pv.rst && pv.grant) begin
            if (pv.req[0]) held.push_back(int'(pv.ep0));
            if (pv.req[1]) held.push_back(int'(pv.ep1));
        end
        apply(pv);
    endtask

    task automatic alloc_all_32();
        run_model(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (15) run_model(mk(0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_model(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t v;
        int   p0;
        int   p1;
        int   idx;
        rst = 1'b0;
        for (int i = 0; i < W; i++) begin
            req[i] = 1'b0;  ren[i] = 1'b0;  rpreg[i] = '0;
        end

        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 32, 0));
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 32 + 2*k, 33 + 2*k, 30 - 2*k, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 40, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 1, 1, 0, 40, 0, 0));
        // Released pregs must not be granted in the same cycle.
        tbl.push_back(mk(0, 2'b11, 2'b11, 40, 33, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 40, 33, 0, 0));
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32, 0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 0, 0, 1, 1, 0, 0, 32, 1));
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32, 0));
        tbl.push_back(mk(0, 2'b00, 2'b10, 0, 50, 1, 1, 0, 0, 32, 1));
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 32, 33, 30, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 34, 35, 28, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 1, 36, 37, 26, 0));
        tbl.push_back(mk(0, 2'b00, 2'b11, 37, 37, 1, 1, 0, 0, 27, 1));
        tbl.push_back(mk(1, 2'b11, 2'b11, 1, 2, 0, 0, 0, 0, 32, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 1, 1, 0, 32, 31, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Full drain, in-order refill and second drain: head wraps past index 63.
        run_model(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        alloc_all_32();
        repeat (16) begin
            p0 = held.pop_front();
            p1 = held.pop_front();
            run_model(mk(0, 2'b00, 2'b11, p0, p1, 0, 0, 0, 0, 0, 0));
        end
        alloc_all_32();

        for (int c = 0; c < 400; c++) begin
            v = mk(0, 2'($urandom_range(0, 3)), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
            if (held.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, held.size() - 1);
                v.rp0 = PW'(held[idx]);
                held.delete(idx);
                v.ren[0] = 1'b1;
            end
            if (held.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, held.size() - 1);
                v.rp1 = PW'(held[idx]);
                held.delete(idx);
                v.ren[1] = 1'b1;
            end
            run_model(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
